// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//
// Exhaustive stimulus generator and checker for an N-input, single-output
// combinational gate-under-test. A start pulse launches a sweep over every
// input vector in binary ascending order. Each vector is held for HOLD
// cycles. On the last cycle of each hold window, the gate output is compared
// with a selectable reference function. Results stay available in DONE until
// the next start: a saturating mismatch count, the first failing vector, and
// a pass flag.
//
// Parameters:
//   N     gate input width (1..8)
//   HOLD  clock cycles each vector is held (>= 1)
//   ERRW  mismatch counter width
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           begin a sweep (honoured only in IDLE or DONE)
//   mode            reference function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR,
//                   5 XNOR, 6 BUF(stim[0]), 7 NOT(stim[0])
//   dut_o           output of the gate-under-test
//   stim            vector driven to the gate-under-test
//   busy            sweep in progress
//   done            sweep finished, held until next start or reset
//   pass            done with zero mismatches
//   err_cnt         saturating mismatch count
//   first_err_vec   stim value of the first mismatch
//   first_err_valid first_err_vec holds a captured value

module gate_sweep_checker #(
    parameter int N    = 2,
    parameter int HOLD = 20,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            dut_o,
    output logic [N-1:0]    stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [N-1:0]    first_err_vec,
    output logic            first_err_valid
);

    // A single-cycle hold still needs a one-bit counter, which then stays at 0.
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [2:0]      mode_q;
    logic [HW-1:0]   hold_cnt;
    logic            expected;
    logic            compare_now;
    logic            mismatch;
    logic            last_vec;
    logic [ERRW-1:0] err_next;

    // Reference output for the current vector.
    // The function is selected by the mode value captured at start, so mode
    // changes during a sweep have no effect.
    always_comb begin
        expected = 1'b0;
        case (mode_q)
            3'd0:    expected = &stim;
            3'd1:    expected = |stim;
            3'd2:    expected = ^stim;
            3'd3:    expected = ~&stim;
            3'd4:    expected = ~|stim;
            3'd5:    expected = ~^stim;
            3'd6:    expected = stim[0];
            3'd7:    expected = ~stim[0];
            default: expected = 1'b0;
        endcase
    end

    // Compare strobe and the mismatch count after this compare.
    // pass is derived from err_next rather than err_cnt. This lets a
    // mismatch on the final vector clear pass on the same edge that raises
    // done.
    always_comb begin
        compare_now = (state == S_RUN) && (hold_cnt == HOLD_LAST);
        mismatch    = compare_now && (dut_o != expected);
        last_vec    = (stim == {N{1'b1}});
        err_next    = err_cnt;
        if (mismatch && (err_cnt != {ERRW{1'b1}})) begin
            err_next = err_cnt + ERRW'(1);
        end
    end

    // Sweep controller and result registers.
    // A start pulse in IDLE or DONE clears all results and launches a sweep.
    // busy rises in the same cycle that stim returns to 0. In RUN, the hold
    // counter paces each vector. At the end of every hold window, one
    // compare is made, and the sweep either advances to the next vector or
    // finishes on the all-ones vector (which stays on stim).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            mode_q          <= 3'd0;
            hold_cnt        <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state           <= S_RUN;
                        mode_q          <= mode;
                        hold_cnt        <= '0;
                        stim            <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (compare_now) begin
                        err_cnt <= err_next;
                        if (mismatch && !first_err_valid) begin
                            first_err_vec   <= stim;
                            first_err_valid <= 1'b1;
                        end
                        if (last_vec) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            stim     <= stim + N'(1);
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
//
// Bench for gate_sweep_checker. It uses two instances:
//   A: N=2, HOLD=20, ERRW=8
//   B: N=3, HOLD=1,  ERRW=2 (for counter saturation)
//
// Each gate-under-test is modelled as a truth table indexed by stim. A
// directed table of {mode, truth table, expected results} drives instance A.
// Hand-written sequences cover reset, ignored start, mid-sweep mode change
// and saturation. Randomised sweeps are scored against a reference that
// counts mismatches straight from the gate definitions.

module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start_a, start_b;
    logic [2:0] mode_a, mode_b;
    logic [3:0] truth_a;
    logic [7:0] truth_b;
    logic       dut_o_a, dut_o_b;

    logic [1:0] stim_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] err_cnt_a;
    logic [1:0] first_err_vec_a;
    logic       first_err_valid_a;

    logic [2:0] stim_b;
    logic       busy_b, done_b, pass_b;
    logic [1:0] err_cnt_b;
    logic [2:0] first_err_vec_b;
    logic       first_err_valid_b;

    assign dut_o_a = truth_a[stim_a];
    assign dut_o_b = truth_b[stim_b];

    gate_sweep_checker #(.N(2), .HOLD(20), .ERRW(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .dut_o(dut_o_a), .stim(stim_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_cnt_a), .first_err_vec(first_err_vec_a),
        .first_err_valid(first_err_valid_a)
    );

    gate_sweep_checker #(.N(3), .HOLD(1), .ERRW(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .dut_o(dut_o_b), .stim(stim_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_cnt_b), .first_err_vec(first_err_vec_b),
        .first_err_valid(first_err_valid_b)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [2:0] mode;
        logic [3:0] truth;
        int         ctl;
        int         exp_err;
        int         exp_first;
        int         exp_valid;
        int         exp_pass;
    } vec_t;

    vec_t tbl[9];

    // Compares one value and reports a FAIL line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reads one output of the selected instance:
    //   0 stim, 1 busy, 2 done, 3 pass, 4 err_cnt,
    //   5 first_err_vec, 6 first_err_valid
    function automatic logic [31:0] rd(input int which, input int sel);
        logic [31:0] v;
        v = 32'd0;
        if (which == 0) begin
            case (sel)
                0: v = 32'(stim_a);
                1: v = 32'(busy_a);
                2: v = 32'(done_a);
                3: v = 32'(pass_a);
                4: v = 32'(err_cnt_a);
                5: v = 32'(first_err_vec_a);
                6: v = 32'(first_err_valid_a);
                default: v = 32'd0;
            endcase
        end else begin
            case (sel)
                0: v = 32'(stim_b);
                1: v = 32'(busy_b);
                2: v = 32'(done_b);
                3: v = 32'(pass_b);
                4: v = 32'(err_cnt_b);
                5: v = 32'(first_err_vec_b);
                6: v = 32'(first_err_valid_b);
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    function automatic string fname(input int sel);
        case (sel)
            0: return "stim";
            1: return "busy";
            2: return "done";
            3: return "pass";
            4: return "err_cnt";
            5: return "first_err_vec";
            default: return "first_err_valid";
        endcase
    endfunction

    // Reference gate output, computed by counting set bits.
    function automatic bit refFn(input int m, input int v, input int n);
        int ones;
        bit b0;
        ones = 0;
        for (int i = 0; i < n; i++) if (((v >> i) & 1) == 1) ones++;
        b0 = bit'(v & 1);
        case (m)
            0: return ones == n;
            1: return ones > 0;
            2: return (ones % 2) == 1;
            3: return ones != n;
            4: return ones == 0;
            5: return (ones % 2) == 0;
            6: return b0;
            default: return !b0;
        endcase
    endfunction

    // Walks every vector of the gate's truth table against the reference.
    task automatic modelSweep(input int m, input logic [7:0] truth, input int n,
                              input int errw, output int e, output int fv,
                              output int fvalid);
        e = 0; fv = 0; fvalid = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (truth[v] != refFn(m, v, n)) begin
                if (e < (1 << errw) - 1) e++;
                if (fvalid == 0) begin
                    fv = v;
                    fvalid = 1;
                end
            end
        end
    endtask

    // Launches one sweep on the selected instance and counts busy cycles.
    // ctl = 1 changes mode at RUN cycle 5 and pulses start at RUN cycle 10.
    // ctl = 2 asserts reset mid-cycle at RUN cycle 30 and checks the outputs.
    task automatic applyStimulus(input int which, input logic [2:0] m,
                                 input logic [7:0] truth, input int ctl,
                                 input string tag, output int cycles,
                                 output int stim_ok);
        int hold;
        int n;
        int limit;
        hold = (which == 0) ? 20 : 1;
        n    = (which == 0) ? 2 : 3;
        limit = (1 << n) * hold + 5;
        @(negedge clk);
        if (which == 0) begin
            truth_a = truth[3:0]; mode_a = m; start_a = 1'b1;
        end else begin
            truth_b = truth; mode_b = m; start_b = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        checkOutput({tag, ".start.busy"}, rd(which, 1), 1);
        checkOutput({tag, ".start.stim"}, rd(which, 0), 0);
        checkOutput({tag, ".start.done"}, rd(which, 2), 0);
        checkOutput({tag, ".start.err_cnt"}, rd(which, 4), 0);
        cycles = 0;
        stim_ok = 1;
        while (rd(which, 1) == 1 && cycles < limit) begin
            cycles++;
            if (rd(which, 0) != 32'((cycles - 1) / hold)) stim_ok = 0;
            if (ctl == 1 && cycles == 5) mode_a = 3'd1;
            if (ctl == 1 && cycles == 10) start_a = 1'b1;
            if (ctl == 1 && cycles == 11) start_a = 1'b0;
            if (ctl == 2 && cycles == 30) begin
                #2 rst_n = 1'b0;
                #1;
                for (int s = 0; s < 7; s++)
                    checkOutput({tag, ".midreset.", fname(s)}, rd(which, s), 0);
                return;
            end
            @(negedge clk);
        end
    endtask

    // Checks the results held in DONE after a completed sweep.
    task automatic checkResult(input int which, input string tag, input int e,
                               input int fv, input int fval, input int n,
                               input int exp_cycles, input int cycles,
                               input int stim_ok);
        checkOutput({tag, ".cycles"}, cycles, exp_cycles);
        checkOutput({tag, ".stim_seq"}, stim_ok, 1);
        checkOutput({tag, ".busy"}, rd(which, 1), 0);
        checkOutput({tag, ".done"}, rd(which, 2), 1);
        checkOutput({tag, ".pass"}, rd(which, 3), (e == 0) ? 1 : 0);
        checkOutput({tag, ".err_cnt"}, rd(which, 4), e);
        checkOutput({tag, ".first_err_vec"}, rd(which, 5), fv);
        checkOutput({tag, ".first_err_valid"}, rd(which, 6), fval);
        checkOutput({tag, ".stim_final"}, rd(which, 0), (1 << n) - 1);
    endtask

    initial begin
        int cyc;
        int sok;
        int e, fv, fval;
        logic [2:0] rm;
        logic [7:0] rt;

        // Directed vectors for instance A: mode, truth[3:0], ctl, err, first, valid, pass.
        tbl[0] = '{3'd0, 4'b1000, 0, 0, 0, 0, 1};
        tbl[1] = '{3'd0, 4'b1110, 0, 2, 1, 1, 0};
        tbl[2] = '{3'd5, 4'b0000, 1, 2, 0, 1, 0};
        tbl[3] = '{3'd1, 4'b1110, 0, 0, 0, 0, 1};
        tbl[4] = '{3'd6, 4'b1010, 0, 0, 0, 0, 1};
        tbl[5] = '{3'd7, 4'b1010, 0, 4, 0, 1, 0};
        tbl[6] = '{3'd3, 4'b0111, 0, 0, 0, 0, 1};
        tbl[7] = '{3'd4, 4'b1000, 0, 2, 0, 1, 0};
        tbl[8] = '{3'd2, 4'b0110, 0, 0, 0, 0, 1};

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        mode_a = 3'd0; mode_b = 3'd0;
        truth_a = 4'd0; truth_b = 8'd0;

        // Reset values, with start held high while in reset.
        #12;
        start_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 7; s++) checkOutput({"reset.", fname(s)}, rd(0, s), 0);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, tbl[i].mode, {4'd0, tbl[i].truth}, tbl[i].ctl,
                          $sformatf("vec%0d", i), cyc, sok);
            checkResult(0, $sformatf("vec%0d", i), tbl[i].exp_err, tbl[i].exp_first,
                        tbl[i].exp_valid, 2, 80, cyc, sok);
            checkOutput($sformatf("vec%0d.pass_tbl", i), rd(0, 3), tbl[i].exp_pass);
        end

        // Mid-sweep reset: a stuck-at-0 gate against XNOR has already logged
        // a mismatch by cycle 30, so a cleared err_cnt proves that no partial
        // result is kept.
        $display("[TB] mid-sweep reset");
        applyStimulus(0, 3'd5, 8'h00, 2, "rst30", cyc, sok);
        start_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst30.start_in_reset.busy", rd(0, 1), 0);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on instance B: an XNOR gate checked against XOR fails
        // every vector.
        $display("[TB] saturation");
        applyStimulus(1, 3'd2, 8'h69, 0, "sat", cyc, sok);
        checkResult(1, "sat", 3, 0, 1, 3, 8, cyc, sok);

        // Randomised sweeps on both instances against the reference model.
        $display("[TB] random sweeps");
        for (int i = 0; i < 6; i++) begin
            rm = 3'($urandom_range(0, 7));
            rt = 8'($urandom);
            rt[7:4] = 4'd0;
            modelSweep(int'(rm), rt, 2, 8, e, fv, fval);
            applyStimulus(0, rm, rt, 0, $sformatf("rndA%0d", i), cyc, sok);
            checkResult(0, $sformatf("rndA%0d", i), e, fv, fval, 2, 80, cyc, sok);
        end
        for (int i = 0; i < 6; i++) begin
            rm = 3'($urandom_range(0, 7));
            rt = 8'($urandom);
            modelSweep(int'(rm), rt, 3, 2, e, fv, fval);
            applyStimulus(1, rm, rt, 0, $sformatf("rndB%0d", i), cyc, sok);
            checkResult(1, $sformatf("rndB%0d", i), e, fv, fval, 3, 8, cyc, sok);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesizable exhaustive stimulus generator and checker for an N-input combinational gate-under-test. It is the in-hardware, parametrised successor to the lab's fixed 2-input gate bench. On `start` it drives every input vector in turn, holding each for a programmable number of cycles. It compares the gate's output against a selectable reference function and reports a mismatch count, the first failing vector, and pass/fail. It sits between the lab top level and any single-output gate module.

## Interface
Parameters:
- `N`, 2, gate input width (1..8)
- `HOLD`, 20, clock cycles each vector is held (>= 1)
- `ERRW`, 8, mismatch counter width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE
- `mode`  in  3  reference function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF(stim[0]), 7 NOT(stim[0])
- `dut_o`  in  1  output of gate-under-test
- `stim`  out  N  vector driven to gate-under-test
- `busy`  out  1  sweep in progress
- `done`  out  1  sweep finished; held until next start or reset
- `pass`  out  1  done and zero mismatches
- `err_cnt`  out  ERRW  mismatch count, saturating
- `first_err_vec`  out  N  stim value of first mismatch
- `first_err_valid`  out  1  first_err_vec holds a captured value

## Operation
- Single clock domain, one asynchronous active-low reset (`rst_n`). All outputs are registered.
- FSM states:
  - IDLE: waits for `start`.
  - RUN: steps through vectors and compares.
  - DONE: reports results.
- FSM transitions:
  - IDLE -(start)-> RUN.
  - RUN -(last compare)-> DONE.
  - DONE -(start)-> RUN.
  - Reset from any state -> IDLE.
- On the start edge:
  - `mode` is latched into an internal register; later `mode` changes are ignored until the next start.
  - stim, err_cnt, first_err_vec, first_err_valid, done and pass are cleared.
  - A hold counter is set to 0.
- RUN behaviour:
  - Vector order is binary ascending, 0 to 2^N-1.
  - The hold counter counts 0..HOLD-1.
  - When hold == HOLD-1, `dut_o` is compared with expected(stim, latched mode).
  - Reduction functions (AND/OR/XOR and their inverses) use all N stim bits.
- On a mismatch:
  - err_cnt increments, saturating at 2^ERRW-1.
  - If first_err_valid == 0, first_err_vec <= stim and first_err_valid <= 1.
- After each compare:
  - If stim == all-ones, the FSM goes to DONE. stim stays at all-ones.
  - Otherwise stim increments and the hold counter returns to 0.
- In DONE:
  - done = 1.
  - pass = (err_cnt == 0).
  - Results are held.
- `start` while in RUN is ignored.
- A mismatch on the final vector is counted before done rises.
- `dut_o` is compared as a 1-bit value; there is no settling filter beyond HOLD.

## Timing
- Reset values: stim 0, busy 0, done 0, pass 0, err_cnt 0, first_err_vec 0, first_err_valid 0, FSM IDLE.
- Start edge:
  - `start` is sampled at edge T.
  - In cycle T+1: busy = 1 and stim = 0.
- Per-vector timing:
  - stim is stable for exactly HOLD cycles per vector.
  - `dut_o` is sampled at the edge closing the HOLD-th cycle of that vector.
- A full sweep occupies 2^N * HOLD cycles of busy = 1.
- At the edge after the last compare:
  - busy falls.
  - done and pass rise.
  - err_cnt holds its final value.
- HOLD = 1: a new vector every cycle, with a compare every cycle.
- Reset mid-sweep: all outputs return to reset values asynchronously. No partial results are retained.
- Restart from DONE: the start edge clears done and pass, and busy rises in the same cycle stim returns to 0.

## Test plan
1. **Reset.** Assert rst_n = 0 mid-cycle.
   - All outputs read 0 immediately.
   - `start` held high during reset has no effect.
2. **Clean AND sweep.** N=2, HOLD=20, mode=0, dut_o = &stim.
   - busy is high for 80 cycles.
   - Ends with done=1, pass=1, err_cnt=0, first_err_valid=0.
3. **Wrong gate (OR as DUT).** mode=0, dut_o = |stim.
   - Mismatches at vectors 01 and 10.
   - Ends with err_cnt=2, first_err_vec=2'b01, first_err_valid=1, pass=0.
4. **Stuck-at-0 DUT against XNOR.** mode=5, dut_o=0.
   - Mismatches at vectors 00 and 11.
   - Ends with err_cnt=2, first_err_vec=2'b00, pass=0.
   - A mode change during RUN does not alter the result.
5. **Counter saturation.** N=3, HOLD=1, ERRW=2, mode=2, dut_o = ~^stim.
   - 8 mismatches occur.
   - err_cnt saturates at 3, first_err_vec=3'b000, and the sweep lasts 8 cycles.
6. **Control.**
   - A start pulse at RUN cycle 10 is ignored: sweep length is unchanged.
   - rst_n low at RUN cycle 30 returns all outputs to 0.
   - A new start from DONE clears the prior err_cnt and completes a fresh sweep.
